// File: rtl/instr_mem_server_if.sv
// Load and fetch bus of the program memory server.
// master: host/controller side; slave: memory side.
interface instr_mem_server_if #(
  parameter int IW = 31,
  parameter int AW = 5
);
  logic          ld_valid;
  logic [IW-1:0] ld_word;
  logic          ld_last;
  logic          ld_ready;
  logic          fetch;
  logic [AW-1:0] pc;
  logic [IW-1:0] instr_word;
  logic          instr_valid;
  logic          fetch_err;

  modport master (
    output ld_valid, ld_word, ld_last,
    output fetch, pc,
    input  ld_ready,
    input  instr_word, instr_valid, fetch_err
  );

  modport slave (
    input  ld_valid, ld_word, ld_last,
    input  fetch, pc,
    output ld_ready,
    output instr_word, instr_valid, fetch_err
  );
endinterface

// File: rtl/instr_mem_server.sv
// Program memory: host loads words, controller fetches them.
// Ports: clk, rst (sync, high), prog, prog_len, ready, bus (slave).
module instr_mem_server #(
  parameter int VEC_ID_WIDTH       = 3,
  parameter int REGFILE_ADDR_WIDTH = 4,
  parameter int DATA_ADDR_WIDTH    = 6,
  parameter int INSTR_ADDR_WIDTH   = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      prog,
  output logic [INSTR_ADDR_WIDTH:0] prog_len,
  output logic                      ready,
  instr_mem_server_if.slave         bus
);
  localparam int AW = INSTR_ADDR_WIDTH;
  localparam int INSTR_W = 2 + VEC_ID_WIDTH
    + 2 * REGFILE_ADDR_WIDTH
    + 3 * DATA_ADDR_WIDTH;
  localparam int PROG_SIZE = 2 ** AW;
  localparam logic [AW:0] LAST_PTR =
    (AW+1)'(PROG_SIZE - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_LOAD = 2'b01,
    S_RUN  = 2'b10
  } state_t;

  state_t state, nxt;

  logic [INSTR_W-1:0] mem [PROG_SIZE];
  logic [AW:0]        wr_ptr;
  logic               accept;
  logic               hit;
  logic               restart;

  assign bus.ld_ready = (state == S_LOAD);
  assign ready        = (state == S_RUN);
  assign accept       = bus.ld_valid & bus.ld_ready;
  assign hit          = ({1'b0, bus.pc} < prog_len);
  assign restart      = prog &&
    (state == S_IDLE || state == S_RUN);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE: if (prog) nxt = S_LOAD;
      S_LOAD: begin
        if (accept) begin
          // A full memory, the last marker or a dropped
          // prog all end the load once the write lands.
          if (bus.ld_last || wr_ptr == LAST_PTR || !prog)
            nxt = S_RUN;
        end else if (!prog) begin
          nxt = (prog_len != '0) ? S_RUN : S_IDLE;
        end
      end
      S_RUN:  if (prog) nxt = S_LOAD;
      default: nxt = S_IDLE;
    endcase
  end

  // Array is never cleared; prog_len gates reads.
  always_ff @(posedge clk) begin
    if (!rst && accept)
      mem[wr_ptr[AW-1:0]] <= bus.ld_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      prog_len <= '0;
    end else if (restart) begin
      wr_ptr   <= '0;
      prog_len <= '0;
    end else if (accept) begin
      // Load ends at LAST_PTR, so this tops out at
      // PROG_SIZE and never wraps.
      wr_ptr   <= wr_ptr + 1'b1;
      prog_len <= wr_ptr + 1'b1;
    end
  end

  // Fetch sees the pre-edge state, so a fetch that
  // coincides with prog=1 in S_RUN uses the old program.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.instr_word  <= '0;
      bus.instr_valid <= 1'b0;
      bus.fetch_err   <= 1'b0;
    end else if (!bus.fetch) begin
      bus.instr_valid <= 1'b0;
      bus.fetch_err   <= 1'b0;
    end else if (state != S_RUN) begin
      bus.instr_valid <= 1'b0;
      bus.fetch_err   <= 1'b1;
    end else if (hit) begin
      bus.instr_word  <= mem[bus.pc];
      bus.instr_valid <= 1'b1;
      bus.fetch_err   <= 1'b0;
    end else begin
      bus.instr_word  <= '0;
      bus.instr_valid <= 1'b0;
      bus.fetch_err   <= 1'b1;
    end
  end
endmodule

// File: tb/tb_instr_mem_server.sv
// Directed bench for instr_mem_server.
// Drives load and fetch phases, checks each output.
module tb_instr_mem_server;
  localparam int IW = 31;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          prog;
  logic [AW:0]   prog_len;
  logic          ready;
  int            n_chk = 0;
  int            n_err = 0;

  instr_mem_server_if #(.IW(IW), .AW(AW)) bus ();

  instr_mem_server dut (
    .clk      (clk),
    .rst      (rst),
    .prog     (prog),
    .prog_len (prog_len),
    .ready    (ready),
    .bus      (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h",
               tag, got, exp);
    end
  endtask

  // Advance one edge; outputs settle 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [IW-1:0] bw(int i);
    return 31'h4000_0000 | IW'(i * 7 + 3);
  endfunction

  logic [IW-1:0] a [4];
  logic [IW-1:0] c [2];

  initial begin
    a[0] = 31'h1111_1111; a[1] = 31'h2222_2222;
    a[2] = 31'h3333_3333; a[3] = 31'h7ABC_DEF0;
    c[0] = 31'h0C0C_0C0C; c[1] = 31'h05A5_A5A5;

    rst = 1'b1; prog = 1'b0;
    bus.ld_valid = 1'b0; bus.ld_word = '0;
    bus.ld_last = 1'b0; bus.fetch = 1'b0;
    bus.pc = '0;

    // T1 reset
    repeat (3) tick();
    chk("rst_word",  bus.instr_word, 0);
    chk("rst_len",   prog_len, 0);
    chk("rst_ready", ready, 0);
    chk("rst_ldrdy", bus.ld_ready, 0);
    chk("rst_valid", bus.instr_valid, 0);
    chk("rst_err",   bus.fetch_err, 0);

    // T2 load 4 words, fetch back
    rst = 1'b0; prog = 1'b1;
    tick();
    chk("t2_ldrdy", bus.ld_ready, 1);
    for (int i = 0; i < 4; i++) begin
      bus.ld_valid = 1'b1;
      bus.ld_word  = a[i];
      bus.ld_last  = (i == 3);
      if (i == 3) prog = 1'b0;
      tick();
    end
    bus.ld_valid = 1'b0; bus.ld_last = 1'b0;
    chk("t2_len",   prog_len, 4);
    chk("t2_ready", ready, 1);
    for (int i = 0; i < 4; i++) begin
      bus.fetch = 1'b1;
      bus.pc    = AW'(i);
      tick();
      chk($sformatf("t2_word%0d", i),
          bus.instr_word, a[i]);
      chk($sformatf("t2_vld%0d", i),
          bus.instr_valid, 1);
    end
    bus.fetch = 1'b0;
    tick();
    chk("t2_idle_vld",  bus.instr_valid, 0);
    chk("t2_idle_hold", bus.instr_word, a[3]);

    // T3 out-of-range fetch
    bus.fetch = 1'b1; bus.pc = 5'd7;
    tick();
    chk("t3_word", bus.instr_word, 0);
    chk("t3_err",  bus.fetch_err, 1);
    chk("t3_vld",  bus.instr_valid, 0);
    bus.fetch = 1'b0;
    tick();
    chk("t3_err_drop", bus.fetch_err, 0);

    // T4 full 32-word load, auto run
    prog = 1'b1;
    tick();
    chk("t4_len0",  prog_len, 0);
    chk("t4_ldrdy", bus.ld_ready, 1);
    for (int i = 0; i < 32; i++) begin
      bus.ld_valid = 1'b1;
      bus.ld_word  = bw(i);
      tick();
    end
    chk("t4_ready", ready, 1);
    chk("t4_len",   prog_len, 32);
    prog = 1'b0; bus.ld_valid = 1'b0;
    bus.fetch = 1'b1; bus.pc = 5'd0;
    tick();
    chk("t4_word0", bus.instr_word, 31'h4000_0003);
    bus.pc = 5'd31;
    tick();
    chk("t4_word31", bus.instr_word, 31'h4000_00DC);
    chk("t4_vld31",  bus.instr_valid, 1);
    chk("t4_stay",   ready, 1);

    // T5 fetch in load, partial load via prog=0
    bus.fetch = 1'b0; prog = 1'b1;
    tick();
    chk("t5_notrdy", ready, 0);
    bus.fetch = 1'b1; bus.pc = 5'd0;
    tick();
    chk("t5_err",  bus.fetch_err, 1);
    chk("t5_vld",  bus.instr_valid, 0);
    chk("t5_hold", bus.instr_word, 31'h4000_00DC);
    bus.fetch = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.ld_valid = 1'b1;
      bus.ld_word  = c[i];
      tick();
    end
    chk("t5_stillload", bus.ld_ready, 1);
    bus.ld_valid = 1'b0; prog = 1'b0;
    tick();
    chk("t5_ready", ready, 1);
    chk("t5_len",   prog_len, 2);
    bus.fetch = 1'b1; bus.pc = 5'd1;
    tick();
    chk("t5_word1", bus.instr_word, c[1]);
    bus.pc = 5'd2;
    tick();
    chk("t5_gate_err",  bus.fetch_err, 1);
    chk("t5_gate_word", bus.instr_word, 0);

    // Fetch and prog on the same edge
    bus.pc = 5'd0; prog = 1'b1;
    tick();
    chk("pf_word",  bus.instr_word, c[0]);
    chk("pf_vld",   bus.instr_valid, 1);
    chk("pf_ldrdy", bus.ld_ready, 1);
    chk("pf_len",   prog_len, 0);

    // T6 reset mid-load
    bus.fetch = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.ld_valid = 1'b1;
      bus.ld_word  = bw(i + 40);
      tick();
    end
    chk("t6_len3", prog_len, 3);
    rst = 1'b1;
    tick();
    chk("t6_len",   prog_len, 0);
    chk("t6_ready", ready, 0);
    chk("t6_ldrdy", bus.ld_ready, 0);
    chk("t6_word",  bus.instr_word, 0);
    rst = 1'b0; prog = 1'b0;
    bus.ld_valid = 1'b0;
    bus.fetch = 1'b1; bus.pc = 5'd0;
    tick();
    chk("t6_err", bus.fetch_err, 1);
    chk("t6_vld", bus.instr_valid, 0);
    bus.fetch = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end
endmodule
